// File: rtl/snoop_arbiter_if.sv
// Snooper-to-core write path bundle.
// drop_cnt exists only with SNOOP_ARB_DROP_CNT_EN.
interface snoop_arbiter_if #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
);
  logic             sn_req;
  logic             sn_wr_en;
  logic             sn_done;
  logic [N-1:0]     core_rdy;
  logic             sn_gnt;
  logic [IDX_W-1:0] sn_sel;
  logic [N-1:0]     core_sel;
  logic [N-1:0]     core_wr_en;
  logic [N-1:0]     core_done;
`ifdef SNOOP_ARB_DROP_CNT_EN
  logic [31:0]      drop_cnt;
`endif

  modport slave (
    input  sn_req,
    input  sn_wr_en,
    input  sn_done,
    input  core_rdy,
    output sn_gnt,
    output sn_sel,
    output core_sel,
    output core_wr_en,
`ifdef SNOOP_ARB_DROP_CNT_EN
    output drop_cnt,
`endif
    output core_done
  );

  modport master (
    output sn_req,
    output sn_wr_en,
    output sn_done,
    output core_rdy,
    input  sn_gnt,
    input  sn_sel,
    input  core_sel,
    input  core_wr_en,
`ifdef SNOOP_ARB_DROP_CNT_EN
    input  drop_cnt,
`endif
    input  core_done
  );
endinterface

// File: rtl/snoop_arbiter.sv
// Round-robin, packet-locked arbiter for the snooper write path.
// Optional drop counter: define SNOOP_ARB_DROP_CNT_EN.
module snoop_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  snoop_arbiter_if.slave  bus
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] rr_nxt;
  logic [IDX_W-1:0] sel_q;
  logic [IDX_W-1:0] sel_nxt;
  logic [N-1:0]     done_q;
  logic [N-1:0]     done_nxt;
  logic [IDX_W-1:0] win;
  logic             any_rdy;
  logic [N-1:0]     sel_oh;

  // Rotating priority scan from rr_ptr, lowest offset wins.
  always_comb begin
    win     = '0;
    any_rdy = |bus.core_rdy;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = int'(rr_ptr) + k;
      if (j >= N) j = j - N;
      if (bus.core_rdy[j]) win = IDX_W'(j);
    end
  end

  // Next-state: arbitrate in IDLE, hold the lock in GRANT.
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    sel_nxt   = sel_q;
    done_nxt  = '0;
    unique case (state)
      IDLE: begin
        if (bus.sn_req && any_rdy) begin
          state_nxt = GRANT;
          sel_nxt   = win;
        end
      end
      GRANT: begin
        if (bus.sn_done) begin
          state_nxt       = IDLE;
          done_nxt[sel_q] = 1'b1;
          if (int'(sel_q) == N - 1) rr_nxt = '0;
          else rr_nxt = sel_q + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, pointer, selection and done pulse registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      sel_q  <= '0;
      done_q <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_nxt;
      sel_q  <= sel_nxt;
      done_q <= done_nxt;
    end
  end

  // One-hot steering derived from the held index.
  always_comb begin
    sel_oh = '0;
    if (state == GRANT) sel_oh[sel_q] = 1'b1;
  end

  assign bus.sn_gnt     = (state == GRANT);
  assign bus.sn_sel     = sel_q;
  assign bus.core_sel   = sel_oh;
  assign bus.core_wr_en = sel_oh & {N{bus.sn_wr_en}};
  assign bus.core_done  = done_q;

`ifdef SNOOP_ARB_DROP_CNT_EN
  logic [31:0] drop_q;

  // Count packets that finished with no buffer, saturating.
  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_q <= '0;
    end else if (state == IDLE && bus.sn_done
                 && drop_q != 32'hFFFF_FFFF) begin
      drop_q <= drop_q + 32'd1;
    end
  end

  assign bus.drop_cnt = drop_q;
`endif

endmodule

// File: doc/snoop_arbiter.md
Name: snoop_arbiter

Overview:
- Shares the snooper's packet-write path between N filter cores, each of which owns packet memory.
- Picks a core that has a free buffer, using round-robin.
- Locks the grant for the whole packet, then signals packet completion to that core.
- Sits between the snooper and the per-core packet memories; it is the only block that steers snooper writes.

Parameters:
- N, 4, number of filter cores sharing the snooper (N >= 2; need not be a power of two).
- IDX_W, $clog2(N), width of the core index.

Ports:
- clk  input  1  single system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-low reset (reset applied when rst==0 at a clk edge).
- sn_req  input  1  snooper has a packet start pending and wants a buffer.
- sn_wr_en  input  1  snooper is writing a packet beat this cycle.
- sn_done  input  1  snooper's last-beat strobe; the packet is finished.
- core_rdy  input  N  bit i high = core i has a free buffer.
- sn_gnt  output  1  a core is allocated to the snooper.
- sn_sel  output  IDX_W  index of the allocated core; valid while sn_gnt is high.
- core_sel  output  N  one-hot write-steering select to the core memories; all zeros when not granted.
- core_wr_en  output  N  sn_wr_en gated onto core_sel (combinational AND).
- core_done  output  N  one-cycle pulse to the allocated core when its packet completes.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, sn_gnt=0, sn_sel=0, core_sel=0, core_done=0.
  - Reset overrides everything, including a grant in progress: the granted core receives no core_done.
- State IDLE:
  - Arbitration runs when sn_req==1 and |core_rdy.
  - Winner = the first index i with core_rdy[i]==1, scanning rr_ptr, rr_ptr+1, ... modulo N.
  - Wrap is explicit: N-1 -> 0.
  - On the next edge: state=GRANT, sn_gnt=1, sn_sel=i, core_sel=1<<i.
  - Grant latency is 1 cycle from the sampled request.
- Requests with no ready core: if sn_req==1 and core_rdy==0, stay in IDLE and re-evaluate every cycle.
- State GRANT:
  - Grant is locked. Changes on core_rdy and sn_req are ignored.
  - core_wr_en = core_sel & {N{sn_wr_en}}.
- Completion: sn_done==1 in GRANT causes, on the next edge:
  - core_done[sn_sel] pulses high for exactly 1 cycle;
  - state=IDLE, sn_gnt=0, core_sel=0;
  - rr_ptr = sn_sel+1 mod N.
- sn_done in IDLE: no grant and no core_done; handled only by the optional drop counter.
- sn_wr_en in IDLE: core_wr_en stays 0 (write discarded).
- sn_req and sn_done together in GRANT: the done is processed and the req is ignored this cycle.
  - The earliest re-grant is 1 cycle after return to IDLE.
  - Back-to-back packets therefore see at least 1 IDLE cycle.
- Fairness: a core that has just been served is considered last on the next arbitration.
- sn_sel is held (not cleared) after the grant ends. Consumers must qualify it with sn_gnt.

Optional Feature:
- Macro: SNOOP_ARB_DROP_CNT_EN.
- When defined:
  - Adds output drop_cnt [31:0], reset 0.
  - Increments by 1 on every cycle with sn_done==1 while state==IDLE (a packet ended with no buffer allocated).
  - Saturates at 32'hFFFFFFFF.
  - Registered: the value updates on the edge after the event.
- When not defined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Basic grant:
  - Stimulus: rst low 2 cycles, then high; core_rdy=4'b1111; sn_req=1.
  - Response: 1 cycle later sn_gnt=1, sn_sel=0, core_sel=4'b0001.
- Completion:
  - Stimulus: continue the previous case with sn_wr_en for 3 cycles, then sn_done=1.
  - Response: core_wr_en[0] high exactly 3 cycles; core_done=4'b0001 for 1 cycle; sn_gnt=0.
- Round-robin and wrap:
  - Stimulus: core_rdy=4'b1111, sn_req held high.
  - Response: successive grants go to cores 0,1,2,3,0.
  - Stimulus: then core_rdy=4'b1001 with rr_ptr=1.
  - Response: grant to 3, then to 0.
- No buffer:
  - Stimulus: core_rdy=0, sn_req=1 for 5 cycles, sn_done pulse.
  - Response: sn_gnt stays 0, core_done=0; with SNOOP_ARB_DROP_CNT_EN, drop_cnt becomes 1.
- Lock under change:
  - Stimulus: granted to core 2, then core_rdy[2] drops to 0 mid-packet.
  - Response: sn_sel stays 2, core_sel=4'b0100 until sn_done; core_done[2] pulses.
- Reset mid-packet:
  - Stimulus: rst=0 while in GRANT.
  - Response: next edge sn_gnt=0, core_sel=0, no core_done pulse; next grant starts from core 0.
